// File: rtl/rv32i_types.sv
// Shared RV32I type definitions: branch funct3 encodings and BHT counter values.
package rv32i_types;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t CTR_SNT = 2'd0;
  localparam bht_ctr_t CTR_WNT = 2'd1;
  localparam bht_ctr_t CTR_WT  = 2'd2;
  localparam bht_ctr_t CTR_ST  = 2'd3;

  // funct3 010/011 are not branch encodings
  function automatic logic is_legal_br(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

endpackage

// File: rtl/bht_array.sv
// Bimodal table of 2-bit saturating counters: async read, sync saturating update.
module bht_array
  import rv32i_types::*;
#(
  parameter int       IDX_W     = 5,
  parameter bht_ctr_t RESET_CTR = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output bht_ctr_t         o_rd_ctr,
  input  logic             i_upd_en,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken
);

  localparam int ENTRIES = 1 << IDX_W;

  bht_ctr_t r_ctr [ENTRIES];
  bht_ctr_t w_cur;
  bht_ctr_t w_nxt;

  // Read returns the pre-update value on a same-index collision
  assign o_rd_ctr = r_ctr[i_rd_idx];
  assign w_cur    = r_ctr[i_upd_idx];

  always_comb begin
    w_nxt = w_cur;
    if (i_upd_taken) begin
      if (w_cur != CTR_ST) w_nxt = w_cur + 2'd1;
    end else begin
      if (w_cur != CTR_SNT) w_nxt = w_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= RESET_CTR;
    end else if (i_upd_en) begin
      r_ctr[i_upd_idx] <= w_nxt;
    end
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch resolution controller: IF-side bimodal prediction, EX-side resolve/flush,
// BHT training and branch/mispredict performance counters.
module branch_pred_ctrl
  import rv32i_types::*;
#(
  parameter int       BHT_IDX_W = 5,
  parameter bht_ctr_t RESET_CTR = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic        if_is_br,
  input  logic [31:0] if_br_target,
  output logic        if_pred_taken,
  output logic [31:0] if_next_pc,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_is_br,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  output logic [2:0]  cmpop,
  input  logic        cmp_out,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  bht_ctr_t       w_if_ctr;
  logic           w_res;
  logic           w_legal;
  logic           w_taken;
  logic           w_upd;
  logic           w_unused;
  logic [31:0]    r_br_count;
  logic [31:0]    r_mispred_count;

  bht_array #(
    .IDX_W     (BHT_IDX_W),
    .RESET_CTR (RESET_CTR)
  ) u_bht (
    .clk         (clk),
    .rst         (rst),
    .i_rd_idx    (if_pc[BHT_IDX_W+1:2]),
    .o_rd_ctr    (w_if_ctr),
    .i_upd_en    (w_upd),
    .i_upd_idx   (ex_pc[BHT_IDX_W+1:2]),
    .i_upd_taken (w_taken)
  );

  assign if_pred_taken = if_is_br & w_if_ctr[1];
  assign if_next_pc    = if_pred_taken ? if_br_target : if_pc + 32'd4;

  assign cmpop = ex_is_br ? ex_funct3 : 3'(beq);

  // Illegal funct3 resolves not-taken but never trains or counts
  assign w_res   = ex_valid & ex_is_br & ~stall & ~rst;
  assign w_legal = is_legal_br(ex_funct3);
  assign w_taken = w_legal & cmp_out;
  assign w_upd   = w_res & w_legal;

  assign flush       = w_res & (w_taken != ex_pred_taken);
  assign redirect_pc = w_taken ? ex_target : ex_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else if (w_upd) begin
      r_br_count <= r_br_count + 32'd1;
      if (flush) r_mispred_count <= r_mispred_count + 32'd1;
    end
  end

  assign br_count      = r_br_count;
  assign mispred_count = r_mispred_count;

  // PC bits outside the BHT index do not affect the table lookup
  assign w_unused = ^{if_pc[31:BHT_IDX_W+2], if_pc[1:0]};

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Self-checking bench for branch_pred_ctrl: directed plan steps plus random traffic
// against an array-based counter model.
module tb_branch_pred_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc, if_br_target, ex_pc, ex_target;
  logic        if_is_br, stall, ex_valid, ex_is_br, ex_pred_taken, cmp_out;
  logic [2:0]  ex_funct3;
  logic        if_pred_taken, flush;
  logic [31:0] if_next_pc, redirect_pc, br_count, mispred_count;
  logic [2:0]  cmpop;

  int n_assert = 0;
  int n_fail   = 0;
  int m_ctr [32];
  int m_br   = 0;
  int m_mis  = 0;

  always #5 clk = ~clk;

  branch_pred_ctrl dut (
    .clk(clk), .rst(rst),
    .if_pc(if_pc), .if_is_br(if_is_br), .if_br_target(if_br_target),
    .if_pred_taken(if_pred_taken), .if_next_pc(if_next_pc),
    .stall(stall), .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_funct3(ex_funct3),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .cmpop(cmpop), .cmp_out(cmp_out), .flush(flush), .redirect_pc(redirect_pc),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) % 32);
  endfunction

  // One clock: check combinational outputs against the model, clock, then check state
  task automatic do_cycle();
    logic e_pred, e_res, e_legal, e_tk, e_fl;
    logic [31:0] e_next, e_rd;
    int ui;
    #1;
    e_pred  = if_is_br && (m_ctr[idx(if_pc)] >= 2);
    e_next  = e_pred ? if_br_target : if_pc + 4;
    e_res   = ex_valid && ex_is_br && !stall && !rst;
    e_legal = !(ex_funct3 == 3'b010 || ex_funct3 == 3'b011);
    e_tk    = e_legal && cmp_out;
    e_fl    = e_res && (e_tk != ex_pred_taken);
    e_rd    = e_tk ? ex_target : ex_pc + 4;
    ui      = idx(ex_pc);
    chk("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, e_pred});
    chk("if_next_pc", if_next_pc, e_next);
    chk("cmpop", {29'd0, cmpop}, {29'd0, (ex_is_br ? ex_funct3 : 3'b000)});
    chk("flush", {31'd0, flush}, {31'd0, e_fl});
    chk("redirect_pc", redirect_pc, e_rd);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_ctr[i] = 1;
      m_br = 0; m_mis = 0;
    end else if (e_res && e_legal) begin
      m_ctr[ui] = e_tk ? ((m_ctr[ui] + 1 > 3) ? 3 : m_ctr[ui] + 1)
                       : ((m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1);
      m_br++;
      if (e_fl) m_mis++;
    end
    #1;
    chk("br_count", br_count, 32'(m_br));
    chk("mispred_count", mispred_count, 32'(m_mis));
  endtask

  task automatic set_ex(input logic v, input logic br, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] tgt,
                        input logic pred, input logic cmp, input logic stl);
    ex_valid = v; ex_is_br = br; ex_funct3 = f3; ex_pc = pc; ex_target = tgt;
    ex_pred_taken = pred; cmp_out = cmp; stall = stl;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_ctr[i] = 1;
    rst = 1'b1; if_pc = 32'h60; if_is_br = 1'b0; if_br_target = 32'h80;
    // Reset with a would-be mispredict in EX: flush must stay low
    set_ex(1, 1, 3'b000, 32'h60, 32'h80, 0, 1, 0);
    do_cycle();
    chk("rst_flush_low", {31'd0, flush}, 32'd0);
    rst = 1'b0;

    // 1. Cold predict
    if_is_br = 1'b1;
    set_ex(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0);
    #1;
    chk("cold_pred", {31'd0, if_pred_taken}, 32'd0);
    chk("cold_next", if_next_pc, 32'h64);
    do_cycle();

    // 2. Mispredict taken
    set_ex(1, 1, 3'b000, 32'h60, 32'h80, 0, 1, 0);
    #1;
    chk("mp_flush", {31'd0, flush}, 32'd1);
    chk("mp_redirect", redirect_pc, 32'h80);
    do_cycle();
    set_ex(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0);
    #1;
    chk("mp_next_pc", if_next_pc, 32'h80);
    chk("mp_br_count", br_count, 32'd1);
    chk("mp_mis_count", mispred_count, 32'd1);

    // 3. Saturation then one not-taken
    for (int k = 0; k < 4; k++) begin
      set_ex(1, 1, 3'b000, 32'h60, 32'h80, 1, 1, 0);
      do_cycle();
    end
    set_ex(1, 1, 3'b000, 32'h60, 32'h80, 1, 0, 0);
    #1;
    chk("sat_nt_redirect", redirect_pc, 32'h64);
    do_cycle();
    set_ex(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0);
    #1;
    chk("sat_still_taken", {31'd0, if_pred_taken}, 32'd1);

    // 4. Stall: bne held three cycles, resolved once on release
    for (int k = 0; k < 3; k++) begin
      set_ex(1, 1, 3'b001, 32'h100, 32'h200, 0, 1, 1);
      do_cycle();
    end
    set_ex(1, 1, 3'b001, 32'h100, 32'h200, 0, 1, 0);
    #1;
    chk("stall_release_flush", {31'd0, flush}, 32'd1);
    do_cycle();
    chk("stall_br_once", br_count, 32'd7);

    // Bring 0x60 down to ctr=1
    set_ex(1, 1, 3'b000, 32'h60, 32'h80, 1, 0, 0);
    do_cycle();

    // 5. Same-index collision: IF sees pre-update value
    set_ex(1, 1, 3'b000, 32'h60, 32'h80, 0, 1, 0);
    #1;
    chk("coll_same_cycle", {31'd0, if_pred_taken}, 32'd0);
    do_cycle();
    set_ex(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0);
    #1;
    chk("coll_next_cycle", {31'd0, if_pred_taken}, 32'd1);

    // 6. Illegal funct3 predicted taken
    set_ex(1, 1, 3'b010, 32'h60, 32'h80, 1, 1, 0);
    #1;
    chk("illegal_flush", {31'd0, flush}, 32'd1);
    chk("illegal_redirect", redirect_pc, 32'h64);
    do_cycle();
    set_ex(1, 1, 3'b011, 32'h60, 32'h80, 0, 1, 0);
    do_cycle();

    // Reset mid-resolve, then a single taken resolve must flip 0x60 to taken
    rst = 1'b1;
    set_ex(1, 1, 3'b000, 32'h60, 32'h80, 0, 1, 0);
    do_cycle();
    rst = 1'b0;
    set_ex(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0);
    #1;
    chk("post_rst_pred", {31'd0, if_pred_taken}, 32'd0);
    chk("post_rst_br", br_count, 32'd0);
    set_ex(1, 1, 3'b000, 32'h60, 32'h80, 0, 1, 0);
    do_cycle();

    // Random traffic over a handful of PCs (some aliasing into the same index)
    for (int k = 0; k < 400; k++) begin
      rst          = ($urandom_range(0, 59) == 0);
      if_pc        = 32'($urandom_range(0, 15)) << 2 | (($urandom_range(0, 1)) << 7);
      if_is_br     = 1'($urandom_range(0, 1));
      if_br_target = $urandom;
      set_ex(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
             3'($urandom_range(0, 7)),
             32'($urandom_range(0, 15)) << 2 | (($urandom_range(0, 1)) << 7),
             $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0));
      do_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
